// File: rtl/entry_pkg.sv
// entry_pkg: shared sizes and FSM states for the digit entry block
package entry_pkg;
  localparam int DIGITS_DEF = 8;
  localparam int RESULT_W = 27;
  localparam int CONV_ITERS = 27;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability-count debouncer and rising-edge event
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      prev <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign rise = level & ~prev;
endmodule

// File: rtl/digit_entry.sv
// digit_entry: button-edited BCD value with sequential BCD-to-binary conversion and load strobe
module digit_entry
  import entry_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_inc,
  input  logic                btn_next,
  input  logic                btn_load,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [2:0]          cursor,
  output logic [31:0]         bin_out,
  output logic                load,
  output logic                busy
);
  localparam int W = 4 * DIGITS + RESULT_W;
  state_t state, nxt;
  logic inc_ev, next_ev, load_ev;
  logic [4:0] iter;
  logic [W-1:0] work, stepped;
  logic [3:0] sel;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (.clk, .rst, .raw(btn_inc), .level(), .rise(inc_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk, .rst, .raw(btn_next), .level(), .rise(next_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (.clk, .rst, .raw(btn_load), .level(), .rise(load_ev));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (load_ev ? CONV : IDLE)
        : state == CONV ? (iter == 5'(CONV_ITERS - 1) ? DONE : CONV)
        : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    load = state == DONE;
  end
  // reverse double-dabble: shift right, then pull every nibble >= 8 back by 3
  always_comb begin
    stepped = work >> 1;
    for (int i = 0; i < DIGITS; i++)
      if (stepped[RESULT_W+4*i +: 4] >= 4'd8) stepped[RESULT_W+4*i +: 4] = stepped[RESULT_W+4*i +: 4] - 4'd3;
  end
  assign sel = bcd_out[{cursor, 2'b00} +: 4];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out <= '0;
      cursor <= '0;
      bin_out <= '0;
      work <= '0;
      iter <= '0;
    end else if (state == IDLE) begin
      if (inc_ev) bcd_out[{cursor, 2'b00} +: 4] <= sel == 4'd9 ? 4'd0 : sel + 4'd1;
      if (next_ev) cursor <= cursor == 3'(DIGITS - 1) ? 3'd0 : cursor + 3'd1;
      if (load_ev) begin
        work <= {bcd_out, RESULT_W'(0)};
        iter <= '0;
      end
    end else if (state == CONV) begin
      work <= stepped;
      iter <= iter + 5'd1;
      if (iter == 5'(CONV_ITERS - 1)) bin_out <= 32'(stepped[RESULT_W-1:0]);
    end
  end
endmodule
